// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory unit.
//   SZ_*         access-size encodings carried on req_size
//   dmem_state_e request FSM states
//   be_mask()    byte-enable mask (up to 8 lanes) for a size and lane
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} dmem_state_e;

  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] lane);
    case (size)
      SZ_BYTE: return 8'h01 << lane;
      SZ_HALF: return 8'h03 << lane;
      SZ_WORD: return 8'h0F << lane;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational lane steering for the data memory.
//   size, lane, is_unsigned : access descriptor
//   wdata                   : right-justified store data
//   rdata_word              : raw memory word being read
//   be                      : byte enables for the store
//   wdata_sh                : store data shifted onto its lane
//   rdata_ext               : load data shifted down and sign/zero extended
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned NB     = DATA_W / 8,
  localparam int unsigned LANE_W = $clog2(NB)
) (
  input  logic [1:0]        size,
  input  logic [LANE_W-1:0] lane,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata_word,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] keep;
  logic              sign;

  assign be       = NB'(be_mask(size, 3'(lane)));
  assign wdata_sh = wdata << {lane, 3'b000};

  // Extension is expressed as a keep-mask so the same code serves DATA_W 32
  // and 64; a full-width access gets keep='1 and passes through untouched.
  always_comb begin
    sh   = rdata_word >> {lane, 3'b000};
    keep = '1;
    sign = 1'b0;
    case (size)
      SZ_BYTE: begin keep = DATA_W'(8'hFF);         sign = sh[7];  end
      SZ_HALF: begin keep = DATA_W'(16'hFFFF);      sign = sh[15]; end
      SZ_WORD: begin keep = DATA_W'(32'hFFFF_FFFF); sign = sh[31]; end
      default: begin keep = '1;                     sign = 1'b0;   end
    endcase
    rdata_ext = (sh & keep) | ({DATA_W{sign & ~is_unsigned}} & ~keep);
  end

endmodule

// File: rtl/dmem_unit.sv
// dmem_unit: clocked data memory with valid/ready request handshake,
// byte/half/word(/dword) access, programmable wait states and error reporting.
//   clk, rst_n        clock, asynchronous active-low reset
//   req_*             request (accepted when req_valid && req_ready)
//   rsp_valid         one-cycle response pulse; rsp_rdata / rsp_err qualify it
// Optional macro DMEM_STATS_EN adds stat_loads / stat_stores / stat_errs
// (32-bit saturating access counters).
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_errs
`endif
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(NB);
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  dmem_state_e state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              req_err;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata_sh, rd_word, rd_ext;

  // Zero at simulation start only; never reset.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    case (req_size)
      SZ_HALF:  req_err = req_addr[0];
      SZ_WORD:  req_err = |req_addr[1:0];
      default:  req_err = (DATA_W == 32) ? 1'b0 : |req_addr[2:0];
    endcase
    if (req_size == SZ_DWORD && DATA_W == 32) req_err = 1'b1;
    if (req_size == SZ_BYTE) req_err = 1'b0;
    if ((req_addr >> LANE_W) >= ADDR_W'(DEPTH)) req_err = 1'b1;
  end

  assign rd_word = mem[idx_q];

  dmem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size        (size_q),
    .lane        (lane_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata_word  (rd_word),
    .be          (be),
    .wdata_sh    (wdata_sh),
    .rdata_ext   (rd_ext)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        size_d  = req_size;
        uns_d   = req_unsigned;
        lane_d  = req_addr[LANE_W-1:0];
        idx_d   = req_addr[LANE_W +: IDX_W];
        wdata_d = req_wdata;
        err_d   = req_err;
        cnt_d   = 4'(WAIT_STATES);
        state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ACCESS;
      end
      ACCESS: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_rdata_d = (err_q || we_q) ? '0 : rd_ext;
        state_d     = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      lane_q      <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ACCESS && we_q && !err_q) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be[b]) mem[idx_q][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
    end
  end

`ifdef DMEM_STATS_EN
  logic [31:0] stat_loads_q, stat_loads_d;
  logic [31:0] stat_stores_q, stat_stores_d;
  logic [31:0] stat_errs_q, stat_errs_d;

  always_comb begin
    stat_loads_d  = stat_loads_q;
    stat_stores_d = stat_stores_q;
    stat_errs_d   = stat_errs_q;
    if (state_q == ACCESS) begin
      if (err_q) begin
        if (stat_errs_q != '1) stat_errs_d = stat_errs_q + 32'd1;
      end else if (we_q) begin
        if (stat_stores_q != '1) stat_stores_d = stat_stores_q + 32'd1;
      end else begin
        if (stat_loads_q != '1) stat_loads_d = stat_loads_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_errs_q   <= '0;
    end else begin
      stat_loads_q  <= stat_loads_d;
      stat_stores_q <= stat_stores_d;
      stat_errs_q   <= stat_errs_d;
    end
  end

  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: directed bench for dmem_unit. Instance 0 has no wait states,
// instance 1 has three; each has its own request and reset signals.
module tb_dmem_unit;
  import dmem_pkg::*;

  localparam int WS1 = 3;

  logic        clk = 1'b0;
  logic        rst_n        [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        rsp_valid    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_err      [2];
`ifdef DMEM_STATS_EN
  logic [31:0] stat_loads   [2];
  logic [31:0] stat_stores  [2];
  logic [31:0] stat_errs    [2];
`endif

  int checks = 0;
  int errors = 0;
  int exp_loads = 0, exp_stores = 0, exp_errs = 0;

  always #5 clk = ~clk;

  dmem_unit #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
`ifdef DMEM_STATS_EN
    , .stat_loads(stat_loads[0]), .stat_stores(stat_stores[0]), .stat_errs(stat_errs[0])
`endif
  );

  dmem_unit #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .WAIT_STATES(WS1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
`ifdef DMEM_STATS_EN
    , .stat_loads(stat_loads[1]), .stat_stores(stat_stores[1]), .stat_errs(stat_errs[1])
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid[d]    = 1'b1;
    req_we[d]       = we;
    req_size[d]     = size;
    req_unsigned[d] = uns;
    req_addr[d]     = addr;
    req_wdata[d]    = wdata;
  endtask

  // One complete transaction: wait for ready, issue, check latency and response.
  task automatic xact(input string tag, input int d, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int lat;
    @(negedge clk);
    n = 0;
    while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
    check({tag, "/ready"}, 64'(req_ready[d]), 64'd1);
    drive(d, we, size, uns, addr, wdata);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 50) begin @(posedge clk); #1; lat++; end
    check({tag, "/lat"}, 64'(lat), 64'((d == 0) ? 2 : WS1 + 2));
    check({tag, "/rdata"}, 64'(rsp_rdata[d]), 64'(exp_rdata));
    check({tag, "/err"}, 64'(rsp_err[d]), 64'(exp_err));
    @(posedge clk);
    #1;
    check({tag, "/pulse"}, 64'(rsp_valid[d]), 64'd0);
    check({tag, "/idle"}, 64'(req_ready[d]), 64'd1);
    if (d == 0) begin
      if (exp_err) exp_errs++;
      else if (we) exp_stores++;
      else exp_loads++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic seen;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      drive(d, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
      req_valid[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst/ready", 64'(req_ready[d]), 64'd1);
      check("rst/valid", 64'(rsp_valid[d]), 64'd0);
      check("rst/rdata", 64'(rsp_rdata[d]), 64'd0);
      check("rst/err",   64'(rsp_err[d]), 64'd0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Basic word store/load, byte merge, extension and errors on instance 0.
    xact("sw10",      0, 1'b1, SZ_WORD,  1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    xact("lw10",      0, 1'b0, SZ_WORD,  1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    xact("sb13",      0, 1'b1, SZ_BYTE,  1'b0, 32'h13, 32'h12345680, 32'h0,        1'b0);
    xact("lb13",      0, 1'b0, SZ_BYTE,  1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0);
    xact("lbu13",     0, 1'b0, SZ_BYTE,  1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0);
    xact("lw10b",     0, 1'b0, SZ_WORD,  1'b0, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0);
    xact("lb11",      0, 1'b0, SZ_BYTE,  1'b0, 32'h11, 32'h0,        32'hFFFFFFBE, 1'b0);
    xact("lh12",      0, 1'b0, SZ_HALF,  1'b0, 32'h12, 32'h0,        32'hFFFF80AD, 1'b0);
    xact("lhu12",     0, 1'b0, SZ_HALF,  1'b1, 32'h12, 32'h0,        32'h000080AD, 1'b0);
    xact("lhu10",     0, 1'b0, SZ_HALF,  1'b1, 32'h10, 32'h0,        32'h0000BEEF, 1'b0);
    xact("sh16",      0, 1'b1, SZ_HALF,  1'b0, 32'h16, 32'hAAAA7FFF, 32'h0,        1'b0);
    xact("lh16",      0, 1'b0, SZ_HALF,  1'b0, 32'h16, 32'h0,        32'h00007FFF, 1'b0);
    xact("lw14",      0, 1'b0, SZ_WORD,  1'b0, 32'h14, 32'h0,        32'h7FFF0000, 1'b0);
    xact("lh11err",   0, 1'b0, SZ_HALF,  1'b0, 32'h11, 32'h0,        32'h0,        1'b1);
    xact("sw12err",   0, 1'b1, SZ_WORD,  1'b0, 32'h12, 32'h11111111, 32'h0,        1'b1);
    xact("lw10c",     0, 1'b0, SZ_WORD,  1'b0, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0);
    xact("lwrange",   0, 1'b0, SZ_WORD,  1'b0, 32'h1000, 32'h0,      32'h0,        1'b1);
    xact("lwlast",    0, 1'b0, SZ_WORD,  1'b0, 32'hFFC, 32'h0,       32'h0,        1'b0);
    xact("ldw32err",  0, 1'b0, SZ_DWORD, 1'b0, 32'h18, 32'h0,        32'h0,        1'b1);

    // Wait states: ready low for five cycles; a held request waits for RESP.
    @(negedge clk);
    drive(1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'hCAFEF00D);
    @(posedge clk);
    #1 drive(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h55555555);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("ws/ready%0d", k), 64'(req_ready[1]), 64'd0);
      check($sformatf("ws/valid%0d", k), 64'(rsp_valid[1]), 64'((k == 5) ? 1 : 0));
      if (k < 5) begin @(posedge clk); #1; end
    end
    check("ws/st_data", 64'(rsp_rdata[1]), 64'd0);
    @(posedge clk);
    #1;
    check("ws/ready6", 64'(req_ready[1]), 64'd1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    check("ws/busy2", 64'(req_ready[1]), 64'd0);
    lat = 1;
    while (!rsp_valid[1] && lat < 50) begin @(posedge clk); #1; lat++; end
    check("ws/lat2", 64'(lat), 64'(WS1 + 2));
    check("ws/rdata2", 64'(rsp_rdata[1]), 64'hCAFEF00D);
    @(posedge clk);
    #1;

    // Reset during WAIT discards the pending store and its response.
    @(negedge clk);
    drive(1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h1234);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(posedge clk);
    #1 rst_n[1] = 1'b0;
    #2;
    check("rstmid/ready", 64'(req_ready[1]), 64'd1);
    #1 rst_n[1] = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (rsp_valid[1]) seen = 1'b1; end
    check("rstmid/norsp", 64'(seen), 64'd0);
    xact("rstmid/lw20", 1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    xact("lw40",        1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0);

`ifdef DMEM_STATS_EN
    check("stat/loads",  64'(stat_loads[0]),  64'(exp_loads));
    check("stat/stores", 64'(stat_stores[0]), 64'(exp_stores));
    check("stat/errs",   64'(stat_errs[0]),   64'(exp_errs));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
